// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-wide data memory.
// Takes one load/store at a time, issues single-cycle re/we pulses, waits
// for mem_valid and returns extended load data. Sub-word stores are done as
// read-modify-write. Illegal, misaligned, out-of-range and timed-out accesses
// return resp_err without touching memory (or without the RMW write).
module mem_access_unit #(
    parameter int ADDRW   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_valid
);

    localparam int TCNTW = $clog2(TIMEOUT + 1);
    localparam logic [TCNTW-1:0] TCNT_LAST = TCNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_RD = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [1:0]        off_r;
    logic [31:0]       wdata_r;
    logic [TCNTW-1:0]  tcnt_r;

    logic              f3_ok_s;
    logic              align_ok_s;
    logic              range_ok_s;
    logic              req_err_s;

    // Select the addressed lane of a memory word and extend it per funct3.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  lane_extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  lane_extract = {{16{sh[15]}}, sh[15:0]};
            3'b010:  lane_extract = sh;
            3'b100:  lane_extract = {24'd0, sh[7:0]};
            3'b101:  lane_extract = {16'd0, sh[15:0]};
            default: lane_extract = 32'd0;
        endcase
    endfunction

    // Merge the low byte/half of the store data into the addressed lane.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'd0, wd[7:0]} << {off, 3'b000};
            end
            3'b001: begin
                mask = 32'h0000_FFFF << {off, 3'b000};
                data = {16'd0, wd[15:0]} << {off, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wd;
            end
        endcase
        lane_merge = (old & ~mask) | (data & mask);
    endfunction

    // Classify the incoming request: legal funct3, alignment, address range.
    always_comb begin
        f3_ok_s    = 1'b0;
        align_ok_s = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
            3'b100, 3'b101:         f3_ok_s = ~req_we;
            default:                f3_ok_s = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   align_ok_s = (req_addr[0] == 1'b0);
            2'b10:   align_ok_s = (req_addr[1:0] == 2'b00);
            default: align_ok_s = 1'b1;
        endcase
        range_ok_s = ((req_addr >> (ADDRW + 2)) == 32'd0);
        req_err_s  = ~(f3_ok_s & align_ok_s & range_ok_s);
    end

    // Request FSM with registered memory pulses and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            f3_r       <= 3'b000;
            off_r      <= 2'b00;
            wdata_r    <= 32'd0;
            tcnt_r     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_din    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_re     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        we_r      <= req_we;
                        f3_r      <= req_funct3;
                        off_r     <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        tcnt_r    <= '0;
                        req_ready <= 1'b0;
                        if (req_err_s) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state_r    <= ST_RESP;
                        end else begin
                            mem_addr <= {2'b00, req_addr[31:2]};
                            if (req_we && (req_funct3 == 3'b010)) begin
                                mem_we  <= 1'b1;
                                mem_din <= req_wdata;
                                state_r <= ST_WAIT;
                            end else begin
                                mem_re  <= 1'b1;
                                state_r <= req_we ? ST_RMW_RD : ST_WAIT;
                            end
                        end
                    end
                end
                ST_RMW_RD: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_valid) begin
                        mem_din <= lane_merge(mem_dout, wdata_r, f3_r, off_r);
                        mem_we  <= 1'b1;
                        tcnt_r  <= '0;
                        state_r <= ST_WAIT;
                    end else if (tcnt_r == TCNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        tcnt_r <= tcnt_r + TCNTW'(1);
                    end
                end
                ST_WAIT: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_r ? 32'd0 : lane_extract(mem_dout, f3_r, off_r);
                        state_r    <= ST_RESP;
                    end else if (tcnt_r == TCNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        tcnt_r <= tcnt_r + TCNTW'(1);
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_re     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-array reference model, scoreboard queue,
// negedge memory responder (valid two cycles after each pulse) and monitor.
module tb_mem_access_unit;

    localparam int ADDRW   = 10;
    localparam int TIMEOUT = 15;
    localparam int LIMIT   = 4 * (1 << ADDRW);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic        mem_valid = 1'b0;

    mem_access_unit #(.ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat_lo;
        int          lat_hi;
        int          n_re;
        int          n_we;
        int          acc_cyc;
        logic [31:0] din;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_bytes [LIMIT];
    logic [31:0] resp_mem [1 << ADDRW];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          re_seen = 0;
    int          we_seen = 0;
    int          resp_cnt = 0;
    int          resp_idx = 0;
    bit          silent = 1'b0;
    bit          prev_re = 1'b0;
    bit          prev_we = 1'b0;
    bit          ready_next = 1'b0;
    logic [31:0] cur_addr_w = 32'd0;
    logic [31:0] cur_din = 32'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: expected response from byte-addressed memory and request rules.
    function automatic exp_t build_exp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd, input bit sil);
        exp_t e;
        int size;
        bit legal;
        bit err;
        logic [31:0] v;
        int base;
        e.rdata = 32'd0; e.err = 1'b0; e.lat_lo = 1; e.lat_hi = 1;
        e.n_re = 0; e.n_we = 0; e.acc_cyc = 0; e.din = 32'd0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = we ? (f3 <= 3'd2) : (size != 0);
        if (!legal) err = 1'b1;
        else err = (addr >= 32'(LIMIT)) || ((addr % 32'(size)) != 32'd0);
        if (err) begin
            e.err = 1'b1;
            return e;
        end
        e.n_re = (!we || size < 4) ? 1 : 0;
        if (sil) begin
            e.err = 1'b1; e.lat_lo = TIMEOUT; e.lat_hi = TIMEOUT + 2;
            e.n_we = (we && size == 4) ? 1 : 0;
            return e;
        end
        if (!we) begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
            if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            e.rdata = v; e.lat_lo = 4; e.lat_hi = 4;
        end else begin
            for (int i = 0; i < size; i++) ref_bytes[int'(addr) + i] = wd[8 * i +: 8];
            base = int'(addr) & ~3;
            e.din = {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
            e.n_we = 1;
            e.lat_lo = (size == 4) ? 4 : 7; e.lat_hi = e.lat_lo;
        end
        return e;
    endfunction

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc = cyc + 1;

    // Memory responder: checks pulses, returns mem_valid two cycles after each pulse.
    always @(negedge clk) begin
        if (mem_valid) mem_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && !silent) begin
                mem_valid = 1'b1;
                mem_dout  = resp_mem[resp_idx];
            end
        end
        if (prev_re) chk("re_width", 32'(mem_re), 32'd0);
        if (prev_we) chk("we_width", 32'(mem_we), 32'd0);
        prev_re = mem_re;
        prev_we = mem_we;
        if (mem_re || mem_we) begin
            chk("mem_addr", mem_addr, cur_addr_w);
            if (mem_we) begin
                chk("mem_din", mem_din, cur_din);
                if (!silent) resp_mem[int'(mem_addr[ADDRW-1:0])] = mem_din;
                we_seen++;
            end
            if (mem_re) re_seen++;
            resp_cnt = 2;
            resp_idx = int'(mem_addr[ADDRW-1:0]);
        end
    end

    // Monitor: pops the scoreboard on every resp_valid and compares.
    always @(negedge clk) begin
        exp_t e;
        int lat;
        if (ready_next) begin
            chk("ready_after_resp", 32'(req_ready), 32'd1);
            ready_next = 1'b0;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp act=resp_valid exp=none t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                lat = cyc - e.acc_cyc;
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("n_re", 32'(re_seen), 32'(e.n_re));
                chk("n_we", 32'(we_seen), 32'(e.n_we));
                total++;
                if (lat < e.lat_lo || lat > e.lat_hi) begin
                    bad++;
                    $display("FAIL latency act=%0d exp=%0d..%0d", lat, e.lat_lo, e.lat_hi);
                end
                ready_next = 1'b1;
            end
            re_seen = 0;
            we_seen = 0;
        end
    end

    // Drive one request (called at a negedge); optionally push its expectation.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit push);
        int waitc = 0;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (!req_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout act=0 exp=1");
            req_valid = 1'b0;
            return;
        end
        cur_addr_w = addr >> 2;
        if (push) begin
            e = build_exp(we, f3, addr, wd, silent);
            e.acc_cyc = cyc;
            cur_din = e.din;
            sb_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait until every expected response has been seen and the unit is idle.
    task automatic drain();
        int waitc = 0;
        while ((sb_q.size() != 0 || !req_ready) && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        total++;
        if (sb_q.size() != 0 || !req_ready) begin
            bad++;
            $display("FAIL drain_timeout act=%0d pending exp=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        logic        w;
        for (int i = 0; i < LIMIT; i++) ref_bytes[i] = 8'h00;
        for (int i = 0; i < (1 << ADDRW); i++) resp_mem[i] = 32'd0;

        // 1: reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // 2: SW then LW
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        drain();
        issue(1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
        drain();

        // 3: SB read-modify-write, then sub-word loads
        issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1);
        drain();
        chk("sb_merged_word", resp_mem[4], 32'hA5ADBEEF);
        issue(1'b0, 3'b000, 32'h13, 32'd0, 1'b1);
        issue(1'b0, 3'b100, 32'h13, 32'd0, 1'b1);
        issue(1'b0, 3'b001, 32'h12, 32'd0, 1'b1);
        issue(1'b1, 3'b001, 32'h16, 32'h1234CAFE, 1'b1);
        issue(1'b0, 3'b101, 32'h16, 32'd0, 1'b1);
        drain();

        // 4: error responses
        issue(1'b0, 3'b001, 32'h11, 32'd0, 1'b1);
        issue(1'b1, 3'b010, 32'h12, 32'h1, 1'b1);
        issue(1'b0, 3'b010, 32'h1000, 32'd0, 1'b1);
        issue(1'b0, 3'b011, 32'h20, 32'd0, 1'b1);
        issue(1'b1, 3'b100, 32'h20, 32'd0, 1'b1);
        issue(1'b0, 3'b010, 32'hFFC, 32'd0, 1'b1);
        drain();

        // 5: silent responder -> timeout, no RMW write
        silent = 1'b1;
        issue(1'b0, 3'b010, 32'h20, 32'd0, 1'b1);
        drain();
        issue(1'b1, 3'b000, 32'h21, 32'h77, 1'b1);
        drain();
        silent = 1'b0;
        repeat (4) @(negedge clk);

        // 6: reset while the SB read is outstanding
        re_seen = 0; we_seen = 0;
        issue(1'b1, 3'b000, 32'h12, 32'h5A, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_mid_no_we", 32'(we_seen), 32'd0);
        chk("rst_mid_one_re", 32'(re_seen), 32'd1);
        chk("rst_mid_ready2", 32'(req_ready), 32'd1);
        re_seen = 0; we_seen = 0;
        issue(1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
        drain();

        // 7: randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom();
                1:       a = 32'hFFC + 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 63));
            endcase
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            issue(w, f, a, $urandom(), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
